command_latch: RTL and testbench
================================

COMMAND_LATCH -- requirements
Module: command_latch

Interface
REQ-001 Ports and reset: the block SHALL have one clock and a synchronous, active-high reset; the clock port is CLOCK and the reset port is rst.
REQ-002 The block SHALL provide these ports, one per line as name / direction / width / meaning:
- CLOCK  in  1  bit-time clock, one bit per cycle.
- rst  in  1  synchronous active-high reset.
- RC  in  1  Read Command state from control gate.
- CI  in  1  complemented serial command input; command bit = ~CI.
- T1  in  1  bit time 1 of each word.
- T29  in  1  bit time 29 (last bit) of each word.
- CMD  out  29  static command; CMD[0] = command bit 1.
- DP  out  1  double-precision flag (bit 1).
- C  out  2  characteristic (bits 2-3).
- S  out  5  source (bits 4-8).
- D  out  5  destination (bits 9-13).
- N  out  7  next-command word time (bits 14-20).
- BP  out  1  breakpoint flag (bit 21).
- T  out  7  timing number (bits 22-28).
- IMM  out  1  immediate/deferred flag (bit 29).
- S_LO  out  8  one-hot decode of S[2:0] (S0..S7).
- S_HI  out  4  one-hot decode of S[4:3] (SU,SV,SW,SX).
- D_LO  out  8  one-hot decode of D[2:0].
- D_HI  out  4  one-hot decode of D[4:3].
- DS  out  1  special command: D == 31 and CMD_VALID.
- CMD_VALID  out  1  static command holds a complete capture.
- CMD_NEW  out  1  one-cycle pulse after a capture.
- CMD_ERR  out  1  sticky capture-sequence error.

Function
REQ-003 Capture FSM SHALL have states IDLE and SHIFT.
REQ-004 IDLE->SHIFT on T1 & RC; in that cycle SR is cleared to {~CI, 28'b0} and bit counter BC is set to 1.
REQ-005 In SHIFT with RC=1 and ~T29: SR <= {~CI, SR[28:1]}, BC <= BC+1, saturating at 31.
REQ-006 SHIFT & RC & T29 with BC == 28 (29th bit): CMD <= {~CI, SR[28:1]}; CMD_VALID <= 1; CMD_NEW pulses high the next cycle; FSM -> IDLE.
REQ-007 SHIFT & RC & T29 with BC != 28: CMD unchanged; CMD_ERR <= 1; FSM -> IDLE.
REQ-008 SHIFT & ~RC (RC dropped mid-word): capture discarded; CMD unchanged; CMD_ERR <= 1; FSM -> IDLE.
REQ-009 T1 & RC while already in SHIFT: restart capture per REQ-004; CMD_ERR <= 1.
REQ-010 RC & T29 in IDLE: ignored; no CMD update.
REQ-011 CMD_VALID SHALL clear on the cycle the FSM enters SHIFT, so the decode is never stale during an RC cycle; the previous CMD value is held.
REQ-012 All field outputs, S_LO/S_HI/D_LO/D_HI and DS SHALL be combinational from the registered CMD and CMD_VALID; the one-hot decodes are valid regardless of CMD_VALID.
REQ-013 Field-to-bit mapping is fixed: command bit k maps to CMD[k-1]; fields are LSB-first in ascending bit order.
REQ-014 Latency: CMD reflects the command on the cycle after the T29 capture cycle, alongside CMD_NEW.
REQ-015 CMD_ERR SHALL clear only on rst.

Reset
REQ-016 On rst: FSM=IDLE; SR=0; BC=0; CMD=0; CMD_VALID=0; CMD_NEW=0; CMD_ERR=0. Outputs then read DP=C=S=D=N=BP=T=IMM=0, S_LO=D_LO=8'b00000001, S_HI=D_HI=4'b0001, DS=0.
REQ-017 rst asserted mid-SHIFT SHALL abort the capture with no CMD update and no CMD_ERR.

Verification
REQ-018 Normal capture: RC=1 over T1..T29 with ~CI serialising 0x1FFFFFFF -> one cycle later CMD=0x1FFFFFFF, DS=1, CMD_VALID=1, and CMD_NEW high for exactly 1 cycle.
REQ-019 Field decode: bits giving S=29, D=5, N=0x55, T=0x2A, IMM=1 -> S_LO[5]=1, S_HI[3]=1, D_LO[5]=1, D_HI[0]=1, DS=0, with N and T exact.
REQ-020 RC drop: RC falls at bit 15 -> CMD keeps its prior value, CMD_ERR=1, FSM back in IDLE; the next full RC capture succeeds with CMD_ERR still 1.
REQ-021 Early T29: T29 pulsed at bit 20 during SHIFT -> no update, CMD_ERR=1.
REQ-022 Reset mid-capture: rst at bit 10 -> all outputs at REQ-016 values, CMD_ERR=0; the next capture works normally.
REQ-023 Back-to-back: two consecutive RC words with different commands -> CMD_VALID low for bits 1-29 of the second word, then the second command is latched and CMD_NEW pulses twice in total.

Source files
------------

// File: rtl/command_latch.sv
// Serial command latch: shifts a 29-bit complemented command word in LSB-first and publishes it as a static decoded command.
// Latency: CMD, CMD_VALID and CMD_NEW update one cycle after the T29 capture cycle; fields and decodes are combinational from CMD.
// Backpressure: none; the latch always accepts the serial stream, and bad framing sets sticky CMD_ERR.
module command_latch (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        RC,
    input  logic        CI,
    input  logic        T1,
    input  logic        T29,
    output logic [28:0] CMD,
    output logic        DP,
    output logic [1:0]  C,
    output logic [4:0]  S,
    output logic [4:0]  D,
    output logic [6:0]  N,
    output logic        BP,
    output logic [6:0]  T,
    output logic        IMM,
    output logic [7:0]  S_LO,
    output logic [3:0]  S_HI,
    output logic [7:0]  D_LO,
    output logic [3:0]  D_HI,
    output logic        DS,
    output logic        CMD_VALID,
    output logic        CMD_NEW,
    output logic        CMD_ERR
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      r_state, w_state_nxt;
    // Bit 0 of the shift register would only ever be shifted out, so it is not kept.
    logic [28:1] r_sr, w_sr_nxt;
    logic [4:0]  r_bc, w_bc_nxt;
    logic [28:0] r_cmd, w_cmd_nxt;
    logic        r_vld, w_vld_nxt;
    logic        r_new, w_new_nxt;
    logic        r_err, w_err_nxt;
    logic        w_bit;

    assign w_bit = ~CI;

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bc_nxt    = r_bc;
        w_cmd_nxt   = r_cmd;
        w_vld_nxt   = r_vld;
        w_new_nxt   = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (T1 && RC) begin
                    w_state_nxt = SHIFT;
                    w_sr_nxt    = {w_bit, 27'b0};
                    w_bc_nxt    = 5'd1;
                    w_vld_nxt   = 1'b0;
                end
            end
            SHIFT: begin
                if (!RC) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else if (T1) begin
                    w_sr_nxt    = {w_bit, 27'b0};
                    w_bc_nxt    = 5'd1;
                    w_vld_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                end else if (T29) begin
                    w_state_nxt = IDLE;
                    if (r_bc == 5'd28) begin
                        w_cmd_nxt = {w_bit, r_sr[28:1]};
                        w_vld_nxt = 1'b1;
                        w_new_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_sr_nxt = {w_bit, r_sr[28:2]};
                    w_bc_nxt = (r_bc == 5'd31) ? r_bc : r_bc + 5'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_bc    <= '0;
            r_cmd   <= '0;
            r_vld   <= 1'b0;
            r_new   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_bc    <= w_bc_nxt;
            r_cmd   <= w_cmd_nxt;
            r_vld   <= w_vld_nxt;
            r_new   <= w_new_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign CMD       = r_cmd;
    assign CMD_VALID = r_vld;
    assign CMD_NEW   = r_new;
    assign CMD_ERR   = r_err;

    assign DP  = r_cmd[0];
    assign C   = r_cmd[2:1];
    assign S   = r_cmd[7:3];
    assign D   = r_cmd[12:8];
    assign N   = r_cmd[19:13];
    assign BP  = r_cmd[20];
    assign T   = r_cmd[27:21];
    assign IMM = r_cmd[28];

    assign S_LO = 8'd1 << S[2:0];
    assign S_HI = 4'd1 << S[4:3];
    assign D_LO = 8'd1 << D[2:0];
    assign D_HI = 4'd1 << D[4:3];
    assign DS   = (D == 5'd31) && r_vld;

endmodule

// File: tb/tb_command_latch.sv
// Randomised bench for command_latch: whole-word stimulus against a word-level model of the latch.
module tb_command_latch;

    logic        CLOCK = 1'b0;
    logic        rst, RC, CI, T1, T29;
    logic [28:0] CMD;
    logic        DP, BP, IMM, DS, CMD_VALID, CMD_NEW, CMD_ERR;
    logic [1:0]  C;
    logic [4:0]  S, D;
    logic [6:0]  N, T;
    logic [7:0]  S_LO, D_LO;
    logic [3:0]  S_HI, D_HI;

    command_latch dut (
        .CLOCK(CLOCK), .rst(rst), .RC(RC), .CI(CI), .T1(T1), .T29(T29),
        .CMD(CMD), .DP(DP), .C(C), .S(S), .D(D), .N(N), .BP(BP), .T(T), .IMM(IMM),
        .S_LO(S_LO), .S_HI(S_HI), .D_LO(D_LO), .D_HI(D_HI), .DS(DS),
        .CMD_VALID(CMD_VALID), .CMD_NEW(CMD_NEW), .CMD_ERR(CMD_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;
    int new_seen = 0;
    int exp_new = 0;
    logic [28:0] exp_cmd;
    logic exp_vld, exp_err, exp_pulse, vld_low_chk;

    always @(negedge CLOCK) if (CMD_NEW === 1'b1) new_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Field of command bits first..last (1-based, LSB-first).
    function automatic logic [31:0] fld(input logic [28:0] c, input int first, input int last);
        logic [31:0] v;
        v = {3'b0, c};
        return (v >> (first - 1)) % (32'd1 << (last - first + 1));
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] s, d;
        s = fld(exp_cmd, 4, 8);
        d = fld(exp_cmd, 9, 13);
        chk({tag, ".cmd"},  CMD,       {3'b0, exp_cmd});
        chk({tag, ".vld"},  CMD_VALID, exp_vld);
        chk({tag, ".err"},  CMD_ERR,   exp_err);
        chk({tag, ".new"},  CMD_NEW,   exp_pulse);
        chk({tag, ".dp"},   DP,   fld(exp_cmd, 1, 1));
        chk({tag, ".c"},    C,    fld(exp_cmd, 2, 3));
        chk({tag, ".s"},    S,    s);
        chk({tag, ".d"},    D,    d);
        chk({tag, ".n"},    N,    fld(exp_cmd, 14, 20));
        chk({tag, ".bp"},   BP,   fld(exp_cmd, 21, 21));
        chk({tag, ".t"},    T,    fld(exp_cmd, 22, 28));
        chk({tag, ".imm"},  IMM,  fld(exp_cmd, 29, 29));
        chk({tag, ".s_lo"}, S_LO, 32'd1 << (s % 8));
        chk({tag, ".s_hi"}, S_HI, 32'd1 << (s / 8));
        chk({tag, ".d_lo"}, D_LO, 32'd1 << (d % 8));
        chk({tag, ".d_hi"}, D_HI, 32'd1 << (d / 8));
        chk({tag, ".ds"},   DS,   (d == 31 && exp_vld) ? 32'd1 : 32'd0);
    endtask

    // Apply one bit-time of inputs and return at the following falling edge.
    task automatic put(input logic t1, input logic t29, input logic rc, input logic b, input logic r);
        T1 = t1; T29 = t29; RC = rc; CI = ~b; rst = r;
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic partial(input logic [28:0] c, input int nbits);
        for (int i = 0; i < nbits; i++) put(i == 0, 1'b0, 1'b1, c[i], 1'b0);
    endtask

    task automatic full_word(input logic [28:0] c);
        for (int i = 0; i < 29; i++) begin
            put(i == 0, i == 28, 1'b1, c[i], 1'b0);
            if (vld_low_chk && i < 28) chk("b2b_vld_low", CMD_VALID, 0);
        end
        exp_cmd = c; exp_vld = 1'b1; exp_new++; exp_pulse = 1'b1;
    endtask

    // mode: 0 normal, 1 RC drop at bit k, 2 early T29 at bit k, 3 reset at bit k, 4 restart at bit k
    task automatic do_word(input int mode, input int k, input logic [28:0] c, input logic [28:0] c2);
        logic rb;
        exp_pulse = 1'b0;
        case (mode)
            0: full_word(c);
            1: begin
                partial(c, k - 1);
                rb = 1'($urandom_range(0, 1));
                put(1'b0, 1'b0, 1'b0, rb, 1'b0);
                exp_vld = 1'b0; exp_err = 1'b1;
            end
            2: begin
                partial(c, k - 1);
                put(1'b0, 1'b1, 1'b1, c[k-1], 1'b0);
                exp_vld = 1'b0; exp_err = 1'b1;
            end
            3: begin
                partial(c, k - 1);
                put(1'b0, 1'b0, 1'b1, c[k-1], 1'b1);
                exp_cmd = '0; exp_vld = 1'b0; exp_err = 1'b0;
            end
            default: begin
                partial(c, k - 1);
                exp_err = 1'b1;
                full_word(c2);
            end
        endcase
    endtask

    // Idle bit-times: T1 never asserted, so stray RC/T29 must be ignored.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++)
            put(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    function automatic logic [28:0] rnd29();
        return 29'($urandom);
    endfunction

    initial begin
        int base, sel, k;
        logic [28:0] c;
        vld_low_chk = 1'b0;
        exp_cmd = '0; exp_vld = 1'b0; exp_err = 1'b0; exp_pulse = 1'b0;
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_outputs("reset");
        chk("reset.s_lo_one", S_LO, 8'b0000_0001);
        chk("reset.d_hi_one", D_HI, 4'b0001);

        do_word(0, 0, 29'h1FFF_FFFF, '0);
        check_outputs("all_ones");
        chk("all_ones.ds", DS, 1);
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("all_ones.new_1cyc", CMD_NEW, 0);
        exp_pulse = 1'b0;

        c = (29'd29 << 3) | (29'd5 << 8) | (29'h55 << 13) | (29'h2A << 21) | (29'd1 << 28);
        do_word(0, 0, c, '0);
        check_outputs("fields");
        chk("fields.s_lo5", S_LO[5], 1);
        chk("fields.s_hi3", S_HI[3], 1);
        chk("fields.d_lo5", D_LO[5], 1);
        chk("fields.d_hi0", D_HI[0], 1);
        chk("fields.ds", DS, 0);
        chk("fields.n", N, 32'h55);
        chk("fields.t", T, 32'h2A);
        gap(2);

        do_word(1, 15, rnd29(), '0);
        check_outputs("rc_drop");
        gap(1);
        do_word(0, 0, rnd29(), '0);
        check_outputs("after_drop");
        gap(1);

        do_word(2, 20, rnd29(), '0);
        check_outputs("early_t29");
        gap(1);

        do_word(3, 10, rnd29(), '0);
        check_outputs("mid_reset");
        do_word(0, 0, rnd29(), '0);
        check_outputs("after_reset");
        gap(1);

        base = new_seen;
        vld_low_chk = 1'b1;
        do_word(0, 0, 29'h0123_4567, '0);
        check_outputs("b2b_first");
        do_word(0, 0, 29'h1765_4321, '0);
        check_outputs("b2b_second");
        vld_low_chk = 1'b0;
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_pulses", new_seen - base, 2);

        for (int w = 0; w < 80; w++) begin
            sel = $urandom_range(0, 9);
            c = rnd29();
            if (sel <= 4) do_word(0, 0, c, '0);
            else if (sel == 5) do_word(1, $urandom_range(2, 29), c, '0);
            else if (sel == 6) do_word(2, $urandom_range(2, 28), c, '0);
            else if (sel == 7) do_word(3, $urandom_range(2, 29), c, '0);
            else begin
                k = $urandom_range(2, 29);
                do_word(4, k, c, rnd29());
            end
            check_outputs("rand");
            gap($urandom_range(0, 3));
        end

        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pulse_total", new_seen, exp_new);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
